// File: rtl/multicore_out_collector_pkg.sv
// Shared multicore constants and the output FIFO entry type.
// Imported by the collector top, its interface, and the bench.
// Optional overrun counter is enabled by COLLECT_OVR_CNT_EN (see top).
package multicore_defs;

  localparam int N_CORES    = 57;
  localparam int DATA_W     = 28;
  localparam int EN_W       = 4;
  localparam int ID_W       = 6;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  // Only this exact out_en code means "result ready"; every other code is ignored.
  localparam logic [EN_W-1:0] EN_VALID = 4'd1;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic [ID_W-1:0]          id;
  } fifo_ent_t;

  // Saturating add used by the drop counter; several cores can drop on one edge.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [6:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {10'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/multicore_out_collector_if.sv
// Output sample stream of the collector: valid/ready with data and core id.
// master = collector side, slave = consumer side.
// No storage here; timing is set by the collector's registered head.
interface multicore_out_collector_if;
  import multicore_defs::*;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [ID_W-1:0]          out_id;

  modport master (output out_valid, output out_data, output out_id, input out_ready);
  modport slave  (input out_valid, input out_data, input out_id, output out_ready);

endinterface

// File: rtl/multicore_out_collector_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester at or above the pointer, else wraps.
// Combinational grant, pointer advances past the winner on the next edge.
// enable low suppresses the grant and freezes the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          enable,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] hi_idx, lo_idx;
  logic          hi_found;

  // Scan downwards so the last hit kept is the lowest index in each range.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_idx   = IW'(i);
          hi_found = 1'b1;
        end
      end
    end
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    gnt_valid = enable && (|req);
    ptr_d     = ptr_q;
    if (gnt_valid) ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multicore_out_collector.sv
// Collects per-core results (out_en==1) into one round-robin ordered, FIFO-buffered stream.
// Latency: capture edge k -> FIFO write at k+1 -> out_valid after k+1 (2 cycles minimum).
// Full FIFO stalls grants; captures on still-pending cores are dropped and flagged.
// Define COLLECT_OVR_CNT_EN to add the 16-bit saturating ovr_cnt output.
module multicore_out_collector
  import multicore_defs::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CORES*DATA_W-1:0]  io_out_bus,
  input  logic [N_CORES*EN_W-1:0]    out_en_bus,
  multicore_out_collector_if.master  out_if,
  output logic [LVL_W-1:0]           fifo_level,
`ifdef COLLECT_OVR_CNT_EN
  output logic [15:0]                ovr_cnt,
`endif
  output logic                       ovr_flag
);

  logic [N_CORES-1:0] pending_q, pending_d, drop;
  logic [DATA_W-1:0]  hold_q [N_CORES];
  logic [DATA_W-1:0]  hold_d [N_CORES];

  fifo_ent_t          mem_q [FIFO_DEPTH];
  fifo_ent_t          mem_d [FIFO_DEPTH];
  fifo_ent_t          head_q, head_d, push_ent;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   count_q, count_d;
  logic               ovr_flag_q, ovr_flag_d;

  logic               pop, full, arb_en, gnt_valid;
  logic [ID_W-1:0]    gnt_idx;

  assign pop      = (count_q != '0) && out_if.out_ready;
  assign full     = (count_q == LVL_W'(FIFO_DEPTH));
  // A slot freed by this cycle's pop may be refilled on the same edge.
  assign arb_en   = !full || pop;
  assign push_ent = '{data: hold_q[gnt_idx], id: gnt_idx};

  rr_arbiter #(.N(N_CORES), .IW(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (pending_q),
    .enable    (arb_en),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Capture: granted core is released first, so a same-edge capture on it reloads cleanly.
  always_comb begin
    pending_d = pending_q;
    hold_d    = hold_q;
    drop      = '0;
    if (gnt_valid) pending_d[gnt_idx] = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (out_en_bus[i*EN_W +: EN_W] == EN_VALID) begin
        if (pending_d[i]) begin
          drop[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          hold_d[i]    = io_out_bus[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // FIFO pointers/storage and the registered head that feeds the outputs.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (gnt_valid) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + LVL_W'(gnt_valid) - LVL_W'(pop);
    if (pop) begin
      if (count_q > LVL_W'(1))  head_d = mem_q[rd_ptr_q + PTR_W'(1)];
      else if (gnt_valid)       head_d = push_ent;
    end else if (count_q == '0 && gnt_valid) begin
      head_d = push_ent;
    end
  end

  // Sticky overrun flag.
  always_comb begin
    ovr_flag_d = ovr_flag_q | (|drop);
  end

  // Collector state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      ovr_flag_q <= 1'b0;
      for (int i = 0; i < N_CORES; i++)    hold_q[i] <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j]  <= '0;
    end else begin
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      ovr_flag_q <= ovr_flag_d;
      hold_q     <= hold_d;
      mem_q      <= mem_d;
    end
  end

`ifdef COLLECT_OVR_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Count every dropped sample, including several cores on one edge.
  always_comb begin
    ovr_cnt_d = sat_add16(ovr_cnt_q, 7'($countones(drop)));
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_cnt_q <= '0;
    else     ovr_cnt_q <= ovr_cnt_d;
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = head_q.data;
  assign out_if.out_id    = head_q.id;
  assign fifo_level       = count_q;
  assign ovr_flag         = ovr_flag_q;

endmodule

// File: tb/tb_multicore_out_collector.sv
// Bench for multicore_out_collector: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations, then randomized traffic.
module tb_multicore_out_collector;
  import multicore_defs::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [N_CORES*DATA_W-1:0] io_out_bus = '0;
  logic [N_CORES*EN_W-1:0]   out_en_bus = '0;
  logic [LVL_W-1:0]          fifo_level;
  logic                      ovr_flag;
`ifdef COLLECT_OVR_CNT_EN
  logic [15:0]               ovr_cnt;
`endif

  multicore_out_collector_if bus();

  multicore_out_collector dut (
    .clk        (clk),
    .rst        (rst),
    .io_out_bus (io_out_bus),
    .out_en_bus (out_en_bus),
    .out_if     (bus),
    .fifo_level (fifo_level),
`ifdef COLLECT_OVR_CNT_EN
    .ovr_cnt    (ovr_cnt),
`endif
    .ovr_flag   (ovr_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  mq_d[$];
  int  mq_id[$];
  bit  m_pend[N_CORES];
  int  m_hold[N_CORES];
  int  m_ptr;
  bit  m_ovr;
  int  m_cnt;

  task automatic model_clear();
    mq_d.delete();
    mq_id.delete();
    for (int i = 0; i < N_CORES; i++) begin
      m_pend[i] = 1'b0;
      m_hold[i] = 0;
    end
    m_ptr = 0;
    m_ovr = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    bit pop;
    int g;
    pop = (mq_d.size() > 0) && bus.out_ready;
    g = -1;
    if (mq_d.size() < FIFO_DEPTH || pop) begin
      for (int k = 0; k < N_CORES; k++) begin
        int c;
        c = (m_ptr + k) % N_CORES;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (pop) begin
      void'(mq_d.pop_front());
      void'(mq_id.pop_front());
    end
    if (g >= 0) begin
      mq_d.push_back(m_hold[g]);
      mq_id.push_back(g);
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % N_CORES;
    end
    for (int i = 0; i < N_CORES; i++) begin
      if (out_en_bus[i*EN_W +: EN_W] == 4'd1) begin
        if (m_pend[i]) begin
          m_ovr = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_pend[i] = 1'b1;
          m_hold[i] = $signed(io_out_bus[i*DATA_W +: DATA_W]);
        end
      end
    end
  endtask

  always @(posedge rst) model_clear();

  // Compare process: advance the model on each edge, check outputs just after it.
  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      model_step();
      #1;
      chk("out_valid", bus.out_valid, mq_d.size() > 0);
      if (mq_d.size() > 0) begin
        chk("out_data", bus.out_data, mq_d[0]);
        chk("out_id", bus.out_id, mq_id[0]);
      end
      chk("fifo_level", fifo_level, mq_d.size());
      chk("ovr_flag", ovr_flag, m_ovr);
`ifdef COLLECT_OVR_CNT_EN
      chk("ovr_cnt", ovr_cnt, m_cnt);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_core(input int c, input logic [3:0] en, input int d);
    out_en_bus[c*EN_W +: EN_W]     = en;
    io_out_bus[c*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      out_en_bus = '0;
    end
  endtask

  task automatic single_core5();
    @(negedge clk);
    bus.out_ready = 1'b1;
    out_en_bus = '0;
    set_core(5, 4'd1, -1234);
    @(posedge clk); #2;
    chk("t1_no_valid_at_capture", bus.out_valid, 0);
    @(negedge clk);
    out_en_bus = '0;
    @(posedge clk); #2;
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_data", bus.out_data, -1234);
    chk("t1_id", bus.out_id, 5);
    chk("t1_level", fifo_level, 1);
    @(posedge clk); #2;
    chk("t1_valid_after_pop", bus.out_valid, 0);
    chk("t1_level_after_pop", fifo_level, 0);
  endtask

  task automatic burst(input int e0, input int e1, input int e2, input string nm);
    int ids[3];
    ids[0] = e0; ids[1] = e1; ids[2] = e2;
    @(negedge clk);
    out_en_bus = '0;
    set_core(0, 4'd1, 100);
    set_core(3, 4'd1, 300);
    set_core(56, 4'd1, 5600);
    @(posedge clk);
    @(negedge clk);
    out_en_bus = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk({nm, "_id"}, bus.out_id, ids[k]);
    end
    @(posedge clk); #2;
    chk({nm, "_empty"}, bus.out_valid, 0);
  endtask

  initial begin
    int seen7;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_id", bus.out_id, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovr", ovr_flag, 0);
`ifdef COLLECT_OVR_CNT_EN
    chk("rst_ovr_cnt", ovr_cnt, 0);
`endif

    // Simultaneous burst with pointer at 0, then again with pointer at 1.
    bus.out_ready = 1'b1;
    burst(0, 3, 56, "burst_p0");
    idle(3);
    @(negedge clk); set_core(0, 4'd1, 7);
    idle(4);
    burst(3, 56, 0, "burst_p1");
    idle(2);

    single_core5();
    idle(2);

    // Non-matching enable codes must not capture.
    @(negedge clk); set_core(10, 4'd2, 42);
    @(negedge clk); out_en_bus = '0; set_core(10, 4'd15, 43);
    idle(4);
    chk("ign_valid", bus.out_valid, 0);
    chk("ign_level", fifo_level, 0);

    // Backpressure: 20 distinct cores, FIFO fills to 16, no drops.
    bus.out_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      out_en_bus = '0;
      set_core(20 + j, 4'd1, j * 1000 - 7000);
    end
    idle(6);
    chk("bp_level_full", fifo_level, 16);
    chk("bp_no_ovr", ovr_flag, 0);
    bus.out_ready = 1'b1;
    idle(30);
    chk("bp_drained", fifo_level, 0);

    // Overrun: FIFO full, core 7 pending with 111, second pulse 222 is dropped.
    bus.out_ready = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      out_en_bus = '0;
      set_core(30 + j, 4'd1, 500 + j);
    end
    @(negedge clk); out_en_bus = '0; set_core(7, 4'd1, 111);
    idle(3);
    chk("ovr_pre_level", fifo_level, 16);
    chk("ovr_pre_flag", ovr_flag, 0);
    @(negedge clk); set_core(7, 4'd1, 222);
    @(posedge clk); #2;
    chk("ovr_flag_set", ovr_flag, 1);
`ifdef COLLECT_OVR_CNT_EN
    chk("ovr_cnt_one", ovr_cnt, 1);
`endif
    @(negedge clk);
    out_en_bus = '0;
    bus.out_ready = 1'b1;
    seen7 = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_id == 7) seen7 = $signed(bus.out_data);
    end
    chk("ovr_old_value_kept", seen7, 111);

    // Reset mid-stream with 8 entries queued.
    bus.out_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      out_en_bus = '0;
      set_core(40 + j, 4'd1, -j);
    end
    idle(3);
    chk("mid_level_8", fifo_level, 8);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ovr", ovr_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    single_core5();

    // Randomized traffic in three backpressure regimes.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < N_CORES; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)      set_core(c, 4'd1, int'($urandom));
        else if (r < 4) set_core(c, 4'($urandom_range(0, 15)), int'($urandom));
        else            set_core(c, 4'd0, int'($urandom));
      end
      if (cyc < 500)       bus.out_ready = ($urandom_range(0, 3) != 0);
      else if (cyc < 1000) bus.out_ready = ($urandom_range(0, 7) == 0);
      else                 bus.out_ready = 1'b1;
    end
    bus.out_ready = 1'b1;
    idle(120);
    chk("final_drained", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicore_out_collector.md
Name: multicore_out_collector

Overview:
- Downstream stage of the 57-core multicore array.
- Captures each core's 28-bit signed result when that core's 4-bit out_en equals 4'd1.
- Serialises the captured results through a round-robin arbiter into one FIFO-buffered valid/ready stream tagged with core index.
- Replaces per-core output handling with a single ordered sink for the file writer or a downstream accumulator.

Parameters:
- N_CORES, 57, number of core result ports.
- DATA_W, 28, signed result width per core.
- EN_W, 4, per-core out_en width.
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=2).
- ID_W, 6, core-index width (ceil(log2(N_CORES))).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- io_out_bus  in  N_CORES*DATA_W  core results, core i at [i*DATA_W +: DATA_W].
- out_en_bus  in  N_CORES*EN_W  core out_en, core i at [i*EN_W +: EN_W].
- out_valid  out  1  out_data/out_id hold a valid sample.
- out_ready  in  1  consumer accepts the sample when out_valid&&out_ready.
- out_data  out  DATA_W  signed sample.
- out_id  out  ID_W  originating core index.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovr_flag  out  1  sticky: a sample was dropped.

Behaviour:
- Reset (async assert, sync release): all pending bits 0, holding regs 0, FIFO empty, arbiter pointer 0, out_valid 0, out_data 0, out_id 0, fifo_level 0, ovr_flag 0.
- Capture: at each edge, for core i with out_en==4'd1 and pending[i]==0, hold[i]<=data and pending[i]<=1. Any other out_en value is ignored.
- Overrun: out_en==4'd1 while pending[i]==1 and core i is not granted that edge. The new sample is dropped, the old one kept, and ovr_flag<=1. ovr_flag clears only on rst.
- Same-edge grant and capture on one core: the granted (old) value goes to the FIFO, the new value loads hold[i], and pending[i] stays 1. This is not an overrun.
- Arbitration: one grant per cycle, round-robin from the pointer. The grant goes to the lowest index >= ptr among pending, wrapping to 0. ptr<=grant+1, wrapping N_CORES-1 -> 0.
- A grant is issued only when the FIFO is not full after this cycle's pop. If pop and push happen on the same edge with the FIFO full, both proceed.
- FIFO: show-ahead. out_valid=!empty. out_data/out_id are driven from a registered head.
- Latency: out_en sampled at edge k -> pending at k -> granted/written at k+1 -> out_valid high after k+1 if the FIFO was empty and no other core pending. Minimum 2 cycles.
- Ordering: per core, FIFO order is capture order. Across cores, order follows round-robin.
- Empty with out_ready=1: no pop, out_valid stays 0.
- Full: no grants; pending cores wait, and further captures on them become overruns.
- Reset mid-stream discards all pending and FIFO contents immediately.

Optional Feature:
- COLLECT_OVR_CNT_EN defined: adds output ovr_cnt (16 bits).
  - Increments once per dropped sample, including multiple cores on one edge (adds popcount).
  - Saturates at 16'hFFFF; reset 0.
- Undefined: port absent; only the sticky ovr_flag reports overruns.

Decomposition:
- Shared include/package `multicore_defs`: DATA_W=28, EN_W=4, N_CORES=57, EN_VALID=4'd1, ID_W=6. The multicore top and testbench use the same constants.
- One sub-module: `rr_arbiter`, parameter N.
  - Inputs: req[N-1:0], enable.
  - Outputs: gnt_valid and gnt_idx.
  - Internal rotating pointer, reset to 0.
- FIFO stays inline.

Test Plan:
- Single core: core 5 out_en=1 with data -1234 for one cycle, out_ready=1 -> exactly one output data -1234, id 5, out_valid rising 2 cycles after capture; fifo_level returns to 0.
- Simultaneous burst: cores 0, 3, 56 pulse out_en=1 same edge, ptr=0 -> outputs in order ids 0, 3, 56 on consecutive cycles; a second burst after ptr=1 starts at 3.
- Backpressure: out_ready=0, 20 distinct single-core pulses -> fifo_level saturates at 16, 4 remain pending, no ovr_flag; release out_ready -> all 20 emerge, per-core order preserved.
- Overrun: FIFO full, core 7 pending, core 7 pulses again with new data -> ovr_flag=1, later output carries the old value; with COLLECT_OVR_CNT_EN, ovr_cnt=1.
- Ignored enable: out_en=4'd2 and 4'd15 on core 10 -> no capture, no output.
- Reset mid-stream: 8 entries queued, rst pulsed asynchronously between edges -> out_valid, fifo_level, ovr_flag drop to 0 immediately; next pulse behaves as first test.
